// File: rtl/trace_logger_mc.sv
// Trace logger between the Tracer stream and a dual-port trace buffer: stores and loads share
// the memory through RW_TURN_I, occupancy gates stores, and a trigger FSM counts post-trigger writes.
module trace_logger_mc #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int DELAY_BITS = 4
) (
  input  logic                       CLK_I,
  input  logic                       RST_NI,
  input  logic                       CONF_TRG_MODE_I,
  input  logic [DELAY_BITS-1:0]      CONF_DELAY_I,
  input  logic                       CONF_CLEAR_I,
  input  logic                       TRG_EVENT_I,
  input  logic [$clog2(WIDTH)-1:0]   EVENT_POS_I,
  output logic                       TRG_DELAYED_O,
  output logic [$clog2(DEPTH)-1:0]   STAT_TRG_PTR_O,
  output logic [$clog2(WIDTH)-1:0]   STAT_EVENT_POS_O,
  output logic                       STAT_STOPPED_O,
  output logic [$clog2(DEPTH):0]     FILL_O,
  input  logic                       RW_TURN_I,
  output logic                       WRITE_O,
  output logic [$clog2(DEPTH)-1:0]   WRITE_PTR_O,
  output logic [WIDTH-1:0]           DMEM_O,
  output logic [$clog2(DEPTH)-1:0]   READ_PTR_O,
  input  logic [WIDTH-1:0]           DMEM_I,
  input  logic [WIDTH-1:0]           DATA_I,
  input  logic                       STORE_I,
  output logic                       STORE_PERM_O,
  output logic [WIDTH-1:0]           DATA_O,
  input  logic                       LOAD_REQUEST_I,
  output logic                       LOAD_GRANT_O
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(WIDTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ARMED, DELAY, STOPPED} state_t;

  state_t                state;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           fill;
  logic                  store_pending;
  logic [WIDTH-1:0]      hold_data;
  logic                  load_pending;
  logic                  read_inflight;
  logic [DELAY_BITS-1:0] cnt;
  logic                  mode_q;
  logic                  trg_delayed;
  logic [AW-1:0]         trg_ptr;
  logic [PW-1:0]         event_pos;

  logic commit;
  logic issue;
  logic store_perm;
  logic accept;

  // The holding word is written in the first write slot; a read is issued only
  // when nothing is already waiting for its data.
  assign commit     = store_pending && !RW_TURN_I;
  assign issue      = RW_TURN_I && load_pending && (fill != '0) && !read_inflight;
  assign store_perm = !store_pending && ((fill + (AW+1)'(store_pending)) < FULL) &&
                      (state != STOPPED);
  assign accept     = STORE_I && store_perm;

  assign STORE_PERM_O     = store_perm;
  assign WRITE_O          = commit;
  assign WRITE_PTR_O      = wptr;
  assign DMEM_O           = hold_data;
  assign READ_PTR_O       = rptr;
  assign LOAD_GRANT_O     = read_inflight;
  assign DATA_O           = read_inflight ? DMEM_I : '0;
  assign FILL_O           = fill;
  assign TRG_DELAYED_O    = trg_delayed;
  assign STAT_TRG_PTR_O   = trg_ptr;
  assign STAT_EVENT_POS_O = event_pos;
  assign STAT_STOPPED_O   = (state == STOPPED);

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state         <= ARMED;
      wptr          <= '0;
      rptr          <= '0;
      fill          <= '0;
      store_pending <= 1'b0;
      hold_data     <= '0;
      load_pending  <= 1'b0;
      read_inflight <= 1'b0;
      cnt           <= '0;
      mode_q        <= 1'b0;
      trg_delayed   <= 1'b0;
      trg_ptr       <= '0;
      event_pos     <= '0;
    end else if (CONF_CLEAR_I) begin
      state         <= ARMED;
      wptr          <= '0;
      rptr          <= '0;
      fill          <= '0;
      store_pending <= 1'b0;
      load_pending  <= 1'b0;
      read_inflight <= 1'b0;
      cnt           <= '0;
      mode_q        <= 1'b0;
      trg_delayed   <= 1'b0;
      trg_ptr       <= '0;
      event_pos     <= '0;
    end else begin
      if (accept) begin
        store_pending <= 1'b1;
        hold_data     <= DATA_I;
      end else if (commit) begin
        store_pending <= 1'b0;
      end

      if (commit) wptr <= wptr + AW'(1);
      if (read_inflight) rptr <= rptr + AW'(1);

      case ({commit, read_inflight})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase

      load_pending  <= read_inflight ? 1'b0 : (load_pending || LOAD_REQUEST_I);
      read_inflight <= issue;

      // The delayed trigger is sticky only while stopped; elsewhere it is a pulse.
      trg_delayed <= trg_delayed && (state == STOPPED);

      case (state)
        ARMED: begin
          if (TRG_EVENT_I) begin
            trg_ptr   <= commit ? (wptr + AW'(1)) : wptr;
            event_pos <= EVENT_POS_I;
            cnt       <= CONF_DELAY_I;
            mode_q    <= CONF_TRG_MODE_I;
            if (CONF_DELAY_I == '0) begin
              trg_delayed <= 1'b1;
              state       <= CONF_TRG_MODE_I ? ARMED : STOPPED;
            end else begin
              state <= DELAY;
            end
          end
        end
        DELAY: begin
          if (commit) begin
            cnt <= cnt - DELAY_BITS'(1);
            if (cnt == DELAY_BITS'(1)) begin
              trg_delayed <= 1'b1;
              state       <= mode_q ? ARMED : STOPPED;
            end
          end
        end
        STOPPED: state <= STOPPED;
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_logger_mc.sv
// Randomized and directed bench for trace_logger_mc with a queue-based reference model and memory model.
module tb_trace_logger_mc;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int DB    = 4;
  localparam int AW    = 6;
  localparam int PW    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0;
  logic [DB-1:0]     delay = '0;
  logic              clear = 1'b0;
  logic              trg = 1'b0;
  logic [PW-1:0]     event_pos = '0;
  logic              trg_delayed;
  logic [AW-1:0]     trg_ptr_o;
  logic [PW-1:0]     epos_o;
  logic              stopped;
  logic [AW:0]       fill;
  logic              turn = 1'b0;
  logic              write_o;
  logic [AW-1:0]     write_ptr;
  logic [WIDTH-1:0]  dmem_o;
  logic [AW-1:0]     read_ptr;
  logic [WIDTH-1:0]  dmem_rd = '0;
  logic [WIDTH-1:0]  data = '0;
  logic              store = 1'b0;
  logic              store_perm;
  logic [WIDTH-1:0]  data_o;
  logic              req = 1'b0;
  logic              grant;

  int checks = 0;
  int errors = 0;
  bit rand_turn = 1'b0;
  logic [WIDTH-1:0] last_wdat, last_gdat;
  logic [AW-1:0]    last_wptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Reference model: committed words as a queue, pointers as running counts.
  logic [WIDTH-1:0] mq[$];
  int wcnt, rcnt, m_phase, m_rem, m_tptr;
  bit m_hold, m_lpend, m_fly, m_mode, m_dly;
  logic [WIDTH-1:0] m_hdat;
  logic [PW-1:0] m_epos;

  trace_logger_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_BITS(DB)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .CONF_TRG_MODE_I(mode), .CONF_DELAY_I(delay),
    .CONF_CLEAR_I(clear), .TRG_EVENT_I(trg), .EVENT_POS_I(event_pos),
    .TRG_DELAYED_O(trg_delayed), .STAT_TRG_PTR_O(trg_ptr_o), .STAT_EVENT_POS_O(epos_o),
    .STAT_STOPPED_O(stopped), .FILL_O(fill), .RW_TURN_I(turn), .WRITE_O(write_o),
    .WRITE_PTR_O(write_ptr), .DMEM_O(dmem_o), .READ_PTR_O(read_ptr), .DMEM_I(dmem_rd),
    .DATA_I(data), .STORE_I(store), .STORE_PERM_O(store_perm), .DATA_O(data_o),
    .LOAD_REQUEST_I(req), .LOAD_GRANT_O(grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_o) mem[write_ptr] <= dmem_o;
    if (turn) dmem_rd <= mem[read_ptr];
  end

  initial begin : turn_drv
    forever begin
      @(posedge clk); #1;
      turn = rand_turn ? 1'($urandom_range(0, 1)) : !turn;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    wcnt = 0; rcnt = 0; m_phase = 0; m_rem = 0; m_tptr = 0;
    m_hold = 0; m_lpend = 0; m_fly = 0; m_mode = 0; m_dly = 0;
    m_hdat = '0; m_epos = '0;
  endtask

  task automatic complete();
    m_dly = 1'b1;
    m_phase = m_mode ? 0 : 2;
  endtask

  initial begin : compare
    bit exp_perm, commit, grant_e, issue;
    int wold;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      exp_perm = !m_hold && (mq.size() < DEPTH) && (m_phase != 2);
      chk("store_perm", 64'(store_perm), 64'(exp_perm));
      chk("write", 64'(write_o), 64'(m_hold && !turn));
      if (m_hold && !turn) begin
        chk("write_ptr", 64'(write_ptr), 64'(wcnt % DEPTH));
        chk("dmem_o", 64'(dmem_o), 64'(m_hdat));
      end
      chk("read_ptr", 64'(read_ptr), 64'(rcnt % DEPTH));
      chk("fill", 64'(fill), 64'(mq.size()));
      chk("load_grant", 64'(grant), 64'(m_fly));
      if (m_fly && mq.size() > 0) chk("data_o", 64'(data_o), 64'(mq[0]));
      chk("trg_delayed", 64'(trg_delayed), 64'(m_dly));
      chk("stopped", 64'(stopped), 64'(m_phase == 2));
      chk("trg_ptr", 64'(trg_ptr_o), 64'(m_tptr));
      chk("event_pos", 64'(epos_o), 64'(m_epos));
      if (rst_n) begin
        if (clear) begin
          model_reset();
        end else begin
          commit  = m_hold && !turn;
          grant_e = m_fly;
          issue   = turn && m_lpend && (mq.size() > 0) && !m_fly;
          wold    = wcnt;
          m_dly   = m_dly && (m_phase == 2);
          if (grant_e) begin
            void'(mq.pop_front());
            rcnt++;
          end
          if (commit) begin
            mq.push_back(m_hdat);
            wcnt++;
            m_hold = 1'b0;
          end
          if (store && exp_perm) begin
            m_hold = 1'b1;
            m_hdat = data;
          end
          m_lpend = grant_e ? 1'b0 : (m_lpend || req);
          m_fly   = issue;
          if (m_phase == 0 && trg) begin
            m_tptr = (wold + int'(commit)) % DEPTH;
            m_epos = event_pos;
            m_mode = mode;
            m_rem  = int'(delay);
            if (m_rem == 0) complete();
            else m_phase = 1;
          end else if (m_phase == 1 && commit) begin
            m_rem--;
            if (m_rem == 0) complete();
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [WIDTH-1:0] d);
    int k;
    store = 1'b1; data = d; k = 0;
    @(negedge clk);
    while (!store_perm && k < 300) begin k++; cyc(); @(negedge clk); end
    chk("store_accept", 64'(store_perm), 64'd1);
    if (!store_perm) begin store = 1'b0; cyc(); return; end
    cyc(); store = 1'b0;
    k = 0;
    @(negedge clk);
    while (!write_o && k < 300) begin k++; cyc(); @(negedge clk); end
    chk("store_commit", 64'(write_o), 64'd1);
    last_wptr = write_ptr;
    last_wdat = dmem_o;
    cyc();
  endtask

  task automatic load_req();
    req = 1'b1; cyc(); req = 1'b0;
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    @(negedge clk);
    while (!grant && k < 400) begin k++; cyc(); @(negedge clk); end
    chk("grant_arrives", 64'(grant), 64'd1);
    last_gdat = data_o;
    cyc();
  endtask

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stim
    int ng, pulses;
    bit stop_seen;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_perm", 64'(store_perm), 64'd1);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_write", 64'(write_o), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_trg", 64'(trg_delayed), 64'd0);
    cyc(); rst_n = 1'b1; cyc();

    // First store lands at address 0.
    do_store(32'hA5A5A5A5);
    chk("first_wptr", 64'(last_wptr), 64'd0);
    chk("first_wdat", 64'(last_wdat), 64'hA5A5A5A5);
    @(negedge clk);
    chk("first_fill", 64'(fill), 64'd1);
    cyc();

    // Fill to capacity, then one load frees a slot.
    for (int i = 0; i < DEPTH - 1; i++) do_store($urandom);
    @(negedge clk);
    chk("full_fill", 64'(fill), 64'd64);
    chk("full_perm", 64'(store_perm), 64'd0);
    cyc();
    load_req(); wait_grant();
    chk("full_load_word0", 64'(last_gdat), 64'hA5A5A5A5);
    @(negedge clk);
    chk("after_load_perm", 64'(store_perm), 64'd1);
    chk("after_load_fill", 64'(fill), 64'd63);
    cyc();
    for (int i = 0; i < DEPTH - 1; i++) begin load_req(); wait_grant(); end

    // Three stores, four loads: the last waits for a new commit.
    do_store(32'h11); do_store(32'h22); do_store(32'h33);
    load_req(); wait_grant(); chk("ld1", 64'(last_gdat), 64'h11);
    load_req(); wait_grant(); chk("ld2", 64'(last_gdat), 64'h22);
    load_req(); wait_grant(); chk("ld3", 64'(last_gdat), 64'h33);
    load_req();
    ng = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (grant) ng++; cyc(); end
    chk("empty_no_grant", 64'(ng), 64'd0);
    do_store(32'h44);
    wait_grant();
    chk("ld4_after_store", 64'(last_gdat), 64'h44);

    // One-shot trigger with delay 5 at write pointer 10.
    for (int i = 0; i < 6; i++) do_store(32'h100 + 32'(i));
    mode = 1'b0; delay = 4'd5; event_pos = 5'd7; trg = 1'b1;
    cyc(); trg = 1'b0; delay = 4'd1;
    @(negedge clk);
    chk("trg_ptr_10", 64'(trg_ptr_o), 64'd10);
    chk("trg_epos_7", 64'(epos_o), 64'd7);
    cyc();
    for (int i = 0; i < 4; i++) do_store(32'h200 + 32'(i));
    @(negedge clk);
    chk("delay_4th_no_trg", 64'(trg_delayed), 64'd0);
    cyc();
    do_store(32'h204);
    @(negedge clk);
    chk("delay_5th_trg", 64'(trg_delayed), 64'd1);
    chk("oneshot_stopped", 64'(stopped), 64'd1);
    chk("stopped_perm", 64'(store_perm), 64'd0);
    cyc();
    load_req(); wait_grant();
    chk("stopped_load", 64'(last_gdat), 64'h100);
    @(negedge clk);
    chk("trg_held", 64'(trg_delayed), 64'd1);
    cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    @(negedge clk);
    chk("clr_fill", 64'(fill), 64'd0);
    chk("clr_stopped", 64'(stopped), 64'd0);
    chk("clr_trg", 64'(trg_delayed), 64'd0);
    chk("clr_trg_ptr", 64'(trg_ptr_o), 64'd0);
    cyc();

    // Continuous mode, zero delay: two single-cycle pulses.
    mode = 1'b1; delay = 4'd0; pulses = 0; stop_seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      trg = (i == 0 || i == 20);
      @(negedge clk);
      if (trg_delayed) pulses++;
      if (stopped) stop_seen = 1'b1;
      cyc();
    end
    trg = 1'b0;
    chk("cont_pulses", 64'(pulses), 64'd2);
    chk("cont_never_stop", 64'(stop_seen), 64'd0);

    // Random slot pattern, 70 stores interleaved with 70 loads across the wrap.
    rand_turn = 1'b1;
    fork
      begin
        for (int i = 0; i < 70; i++) begin
          do_store($urandom);
          repeat ($urandom_range(0, 3)) cyc();
        end
      end
      begin
        for (int j = 0; j < 70; j++) begin
          load_req(); wait_grant();
          repeat ($urandom_range(0, 3)) cyc();
        end
      end
    join

    // Clear in the middle of a delay.
    mode = 1'b0; delay = 4'd9; trg = 1'b1; cyc(); trg = 1'b0;
    do_store(32'hBEEF0001); do_store(32'hBEEF0002); do_store(32'hBEEF0003);
    @(negedge clk);
    chk("mid_delay_running", 64'(stopped), 64'd0);
    cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    @(negedge clk);
    chk("clr2_fill", 64'(fill), 64'd0);
    chk("clr2_wptr", 64'(write_ptr), 64'd0);
    chk("clr2_rptr", 64'(read_ptr), 64'd0);
    chk("clr2_stopped", 64'(stopped), 64'd0);
    cyc();
    mode = 1'b1; delay = 4'd0; trg = 1'b1; cyc(); trg = 1'b0;
    @(negedge clk);
    chk("clr2_rearmed", 64'(trg_delayed), 64'd1);
    cyc();

    // Asynchronous reset with a word in the holding register.
    rand_turn = 1'b0;
    do_store(32'hC0DE0001);
    store = 1'b1; data = 32'hC0DE0002;
    @(negedge clk);
    chk("pre_rst_perm", 64'(store_perm), 64'd1);
    cyc(); store = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_fill", 64'(fill), 64'd0);
    chk("mid_rst_write", 64'(write_o), 64'd0);
    chk("mid_rst_perm", 64'(store_perm), 64'd1);
    cyc(); rst_n = 1'b1;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
